mont_redc: RTL
==============

MONT_REDC -- requirements
Module: mont_redc

Interface
REQ-001 Parameter DAT_BITS, 256, width of modulus and reduced result.
REQ-002 Parameter CTL_BITS, 8, width of ctl sideband carried through unchanged.
REQ-003 Parameter WORD_W, 64, digit width reduced per iteration; DAT_BITS SHALL be a multiple of WORD_W.
REQ-004 Parameter P, BN254 Fq 0x30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47, odd modulus.
REQ-005 Parameter P_INV_NEG, 0x87d20782e4866389, equal to -P^-1 mod 2^WORD_W.
REQ-006 i_clk  input  1  sole clock, all logic on rising edge.
REQ-007 i_rst  input  1  asynchronous, active-high reset.
REQ-008 i_red  if_axi_stream sink  dat 2*DAT_BITS  product T from multiplier, with ctl/sop/eop/err/mod.
REQ-009 o_red  if_axi_stream source  dat 2*DAT_BITS  result T*R^-1 mod P in dat[DAT_BITS-1:0], upper bits zero.

Function
REQ-010 Block SHALL compute T*2^-DAT_BITS mod P (R = 2^DAT_BITS) for any input T < P*R.
REQ-011 Output value SHALL be fully reduced: 0 <= o_red.dat < P.
REQ-012 FSM states IDLE, REDUCE, SUB, OUT; one transaction in flight.
REQ-013 IDLE: i_red.rdy = 1; on i_red.val & i_red.rdy capture T, ctl, err, go to REDUCE with iteration counter = 0.
REQ-014 REDUCE: each cycle m = (acc[WORD_W-1:0] * P_INV_NEG) mod 2^WORD_W; acc = (acc + m*P) >> WORD_W; counter increments.
REQ-015 After DAT_BITS/WORD_W REDUCE cycles go to SUB; SUB: if acc >= P then acc = acc - P; go to OUT.
REQ-016 Accumulator SHALL be 2*DAT_BITS+1 bits wide at load and never overflow; only DAT_BITS+1 bits are significant in SUB.
REQ-017 OUT: o_red.val = 1 with dat, ctl, err stable; on o_red.rdy go to IDLE.
REQ-018 Latency: acceptance at cycle 0 SHALL give o_red.val at cycle DAT_BITS/WORD_W + 2 (6 for defaults) when unstalled.
REQ-019 i_red.rdy SHALL be 0 in REDUCE, SUB, OUT; no combinational path from o_red.rdy to i_red.rdy.
REQ-020 o_red.sop = o_red.eop = 1, o_red.mod = 0 on every output beat; single-beat transactions only.
REQ-021 o_red.err SHALL equal captured i_red.err; computation proceeds regardless of err.
REQ-022 Holding o_red.rdy low SHALL hold all o_red fields stable indefinitely.

Reset
REQ-023 On i_rst: FSM = IDLE, counter = 0, o_red.val = 0, o_red.dat/ctl/err = 0, i_red.rdy = 0 while i_rst asserted.
REQ-024 Reset mid-transaction SHALL discard it; no output for it after reset release.
REQ-025 i_red.rdy SHALL assert on first clock edge after reset deassertion.

Structure
REQ-026 P, P_INV_NEG and DAT_BITS defaults for BN254 Fq SHALL live in a shared package (bn128_pkg) and feed the parameters.
REQ-027 The per-iteration m and m*P row computation SHALL be one combinational sub-module, mont_redc_step.
REQ-028 A single mont_redc SHALL sit directly downstream of multiplier, o_mul connected to i_red.

Verification
REQ-029 T = 2^256 -> o_red.dat = 1, valid 6 cycles after acceptance.
REQ-030 T = 0 -> 0; T = P -> 0; T = (P-1)*2^256 -> P-1.
REQ-031 1000 random a,b < P, T = a*b, ctl = loop index -> dat = a*b*R^-1 mod P (model), ctl echoed, err 0.
REQ-032 Backpressure: o_red.rdy low 10 cycles -> output stable, i_red.rdy 0 throughout, next input accepted the cycle after handshake completes.
REQ-033 i_rst pulse at REDUCE iteration 2 -> no output beat, i_red.rdy high next cycle after release, next result correct.
REQ-034 i_red.err = 1 with T = 2^256 -> o_red.err = 1, dat = 1.

Source files
------------

// File: rtl/bn128_pkg.sv
// BN254 (alt_bn128) base-field constants and the Montgomery reducer's shared types.
package bn128_pkg;

    localparam int BN_DAT_BITS = 256;
    localparam int BN_WORD_W   = 64;

    localparam logic [BN_DAT_BITS-1:0] BN_P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    // -P^-1 mod 2^64
    localparam logic [BN_WORD_W-1:0] BN_P_INV_NEG = 64'h87d20782e4866389;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_SUB    = 2'd2,
        ST_OUT    = 2'd3
    } red_state_t;

    // Byte-count field width for a stream carrying 2*dat_bits of data.
    function automatic int mod_bits(input int dat_bits);
        return $clog2(2 * dat_bits / 8);
    endfunction

endpackage

// File: rtl/mont_redc_step.sv
// One word of Montgomery reduction: picks m so the low word of acc + m*P is zero.
module mont_redc_step
    import bn128_pkg::*;
#(
    parameter int                  DAT_BITS  = BN_DAT_BITS,
    parameter int                  WORD_W    = BN_WORD_W,
    parameter logic [DAT_BITS-1:0] P         = BN_P,
    parameter logic [WORD_W-1:0]   P_INV_NEG = BN_P_INV_NEG
) (
    input  logic [WORD_W-1:0]          i_lo,
    output logic [DAT_BITS+WORD_W-1:0] o_row
);
    localparam int ROW_W = DAT_BITS + WORD_W;

    logic [WORD_W-1:0] w_m;

    assign w_m   = i_lo * P_INV_NEG;
    assign o_row = ROW_W'(w_m) * ROW_W'(P);

endmodule

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction T*2^-DAT_BITS mod P, one transaction in flight.
module mont_redc
    import bn128_pkg::*;
#(
    parameter int                  DAT_BITS  = BN_DAT_BITS,
    parameter int                  CTL_BITS  = 8,
    parameter int                  WORD_W    = BN_WORD_W,
    parameter logic [DAT_BITS-1:0] P         = BN_P,
    parameter logic [WORD_W-1:0]   P_INV_NEG = BN_P_INV_NEG,
    parameter int                  MOD_BITS  = mod_bits(DAT_BITS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // i_red_* is the sink bundle, o_red_* the source bundle (rdy runs against the bundle direction)
    input  logic                  i_red_val,
    output logic                  i_red_rdy,
    input  logic [2*DAT_BITS-1:0] i_red_dat,
    input  logic [CTL_BITS-1:0]   i_red_ctl,
    input  logic                  i_red_sop,
    input  logic                  i_red_eop,
    input  logic                  i_red_err,
    input  logic [MOD_BITS-1:0]   i_red_mod,
    output logic                  o_red_val,
    input  logic                  o_red_rdy,
    output logic [2*DAT_BITS-1:0] o_red_dat,
    output logic [CTL_BITS-1:0]   o_red_ctl,
    output logic                  o_red_sop,
    output logic                  o_red_eop,
    output logic                  o_red_err,
    output logic [MOD_BITS-1:0]   o_red_mod,
    output logic [1:0]            o_dbg_state
);
    localparam int ACC_W = 2 * DAT_BITS + 1;
    localparam int ROW_W = DAT_BITS + WORD_W;
    localparam int ITERS = DAT_BITS / WORD_W;
    localparam int CNT_W = $clog2(ITERS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    red_state_t           r_state;
    red_state_t           w_state_nxt;
    logic                 r_live;
    logic [CNT_W-1:0]     r_cnt;
    logic [ACC_W-1:0]     r_acc;
    logic [CTL_BITS-1:0]  r_ctl;
    logic                 r_err;
    logic [ROW_W-1:0]     w_row;
    logic [ACC_W:0]       w_sum;
    logic [ACC_W-1:0]     w_acc_red;
    logic                 w_ge;
    logic [DAT_BITS:0]    w_diff;
    logic                 w_accept;
    logic                 w_unused;

    // Single-beat stream: framing inputs carry no information for this block.
    assign w_unused = ^{i_red_sop, i_red_eop, i_red_mod};

    mont_redc_step #(
        .DAT_BITS  (DAT_BITS),
        .WORD_W    (WORD_W),
        .P         (P),
        .P_INV_NEG (P_INV_NEG)
    ) u_step (
        .i_lo  (r_acc[WORD_W-1:0]),
        .o_row (w_row)
    );

    // Low word of the sum is zero by construction, so the shift is exact.
    assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(w_row);
    assign w_acc_red = ACC_W'(w_sum >> WORD_W);
    assign w_ge      = r_acc[DAT_BITS:0] >= {1'b0, P};
    assign w_diff    = r_acc[DAT_BITS:0] - {1'b0, P};

    always_comb begin
        w_state_nxt = r_state;
        i_red_rdy   = 1'b0;
        o_red_val   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                i_red_rdy = r_live;
                w_accept  = i_red_val & r_live;
                if (w_accept) w_state_nxt = ST_REDUCE;
            end
            ST_REDUCE: if (r_cnt == LAST) w_state_nxt = ST_SUB;
            ST_SUB:    w_state_nxt = ST_OUT;
            ST_OUT: begin
                o_red_val = 1'b1;
                if (o_red_rdy) w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ctl   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_acc <= {1'b0, i_red_dat};
                    r_ctl <= i_red_ctl;
                    r_err <= i_red_err;
                    r_cnt <= '0;
                end
                ST_REDUCE: begin
                    r_acc <= w_acc_red;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_SUB: if (w_ge) r_acc <= ACC_W'(w_diff);
                default: ;
            endcase
        end
    end

    assign o_red_dat   = {{DAT_BITS{1'b0}}, r_acc[DAT_BITS-1:0]};
    assign o_red_ctl   = r_ctl;
    assign o_red_err   = r_err;
    assign o_red_sop   = 1'b1;
    assign o_red_eop   = 1'b1;
    assign o_red_mod   = '0;
    assign o_dbg_state = r_state;

endmodule
